dot_product_engine: RTL and testbench

//  Sequencer + MAC for the dot-product datapath. Sweeps a shared read address

---
 rtl/dot_product_engine.sv | 85 ++++++++
 tb/tb_dot_product_engine.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_engine.sv
// dot_product_engine: sweeps a shared read address over vector memories A and B and accumulates signed products
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start, len, base_addr   request; len/base_addr captured with start in IDLE
//   busy                    high whenever not IDLE
//   rd_en, rd_addr          read strobe and shared address to both memories (latency 1)
//   a_data, b_data          registered memory outputs
//   result, result_valid,
//   result_ready            scalar result on a valid/ready handshake
module dot_product_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state;
  logic [ADDR_WIDTH:0] rem;
  logic pipe;
  logic signed [ACC_WIDTH-1:0] a_ext, b_ext, prod, acc;
  always_comb begin
    a_ext = {{(ACC_WIDTH-DATA_WIDTH){a_data[DATA_WIDTH-1]}}, a_data};
    b_ext = {{(ACC_WIDTH-DATA_WIDTH){b_data[DATA_WIDTH-1]}}, b_data};
    prod  = a_ext * b_ext;
  end
  // pipe marks that the memories sampled rd_en last edge, so their data is valid now.
  // len=0 passes through DRAIN with an empty pipe, so result=0 lands one edge later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      rem          <= '0;
      pipe         <= 1'b0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      pipe <= rd_en;
      if (pipe) acc <= acc + prod;
      case (state)
        IDLE: if (start) begin
          acc     <= '0;
          rem     <= len;
          rd_addr <= base_addr;
          busy    <= 1'b1;
          rd_en   <= len != '0;
          state   <= len == '0 ? DRAIN : READ;
        end
        READ: if (rem == (ADDR_WIDTH+1)'(1)) begin
          rd_en <= 1'b0;
          state <= DRAIN;
        end else begin
          rd_addr <= rd_addr + 1'b1;
          rem     <= rem - 1'b1;
        end
        DRAIN: if (!pipe) begin
          result       <= acc;
          result_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: if (result_ready) begin
          result_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_product_engine.sv
// tb_dot_product_engine: randomized self-checking bench with memory models and an arithmetic reference
module tb_dot_product_engine;
  logic clk = 0, rst_n = 0, start = 0, result_ready = 0;
  logic [4:0] len = 0;
  logic [3:0] base_addr = 0;
  logic busy, rd_en, result_valid;
  logic [3:0] rd_addr;
  logic [7:0] a_data = 0, b_data = 0;
  logic [19:0] result;
  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];
  int vectors = 0, errs = 0;
  int addrs[$];
  int rd_first, rd_last, vedge;
  dot_product_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .base_addr(base_addr),
    .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .a_data(a_data), .b_data(b_data),
    .result(result), .result_valid(result_valid), .result_ready(result_ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) begin
    a_data <= mem_a[rd_addr];
    b_data <= mem_b[rd_addr];
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [19:0] model(input int b, input int l);
    longint s = 0;
    for (int k = 0; k < l; k++)
      s += longint'($signed(mem_a[(b + k) % 16])) * longint'($signed(mem_b[(b + k) % 16]));
    return s[19:0];
  endfunction
  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
  endtask
  // Issues one start and watches until result_valid (bounded); records reads and latency.
  task automatic run_op(input int b, input int l);
    base_addr = 4'(b);
    len = 5'(l);
    start = 1;
    tick();
    start = 0;
    addrs.delete();
    rd_first = -1;
    rd_last = -1;
    vedge = -1;
    for (int e = 0; e < 60; e++) begin
      if (rd_en) begin
        if (rd_first < 0) rd_first = e;
        rd_last = e;
        addrs.push_back(int'(rd_addr));
      end
      if (result_valid) begin
        vedge = e;
        break;
      end
      tick();
    end
  endtask
  task automatic handshake();
    result_ready = 1;
    tick();
    result_ready = 0;
  endtask
  task automatic check_op(input string name, input int b, input int l, input logic [19:0] exp);
    vectors++;
    if (result !== exp) begin
      errs++;
      $display("FAIL %s result: got %0d expected %0d", name, $signed(result), $signed(exp));
    end
    vectors++;
    if (vedge !== (l == 0 ? 1 : l + 2)) begin
      errs++;
      $display("FAIL %s valid_edge: got %0d expected %0d", name, vedge, l == 0 ? 1 : l + 2);
    end
    vectors++;
    if (addrs.size() !== l || (l > 0 && (rd_first !== 0 || rd_last !== l - 1))) begin
      errs++;
      $display("FAIL %s rd_window: got %0d reads edges %0d..%0d expected %0d reads edges 0..%0d",
               name, addrs.size(), rd_first, rd_last, l, l - 1);
    end
    for (int k = 0; k < addrs.size() && k < l; k++) begin
      vectors++;
      if (addrs[k] !== (b + k) % 16) begin
        errs++;
        $display("FAIL %s rd_addr[%0d]: got %0d expected %0d", name, k, addrs[k], (b + k) % 16);
      end
    end
  endtask
  task automatic test_reset();
    rst_n = 0;
    tick();
    tick();
    vectors++;
    if ({busy, rd_en, result_valid} !== 3'b000 || rd_addr !== 4'd0 || result !== 20'd0) begin
      errs++;
      $display("FAIL reset: got busy=%b rd_en=%b valid=%b addr=%0d result=%0d expected all 0",
               busy, rd_en, result_valid, rd_addr, result);
    end
    rst_n = 1;
    tick();
  endtask
  task automatic test_basic();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'(i + 1);
      mem_b[i] = 8'(i + 5);
    end
    run_op(0, 4);
    check_op("basic", 0, 4, 20'd70);
    handshake();
  endtask
  task automatic test_signed();
    mem_a[0] = 8'h80; mem_a[1] = 8'h80;
    mem_b[0] = 8'h80; mem_b[1] = 8'h7f;
    run_op(0, 2);
    check_op("signed_pair", 0, 2, 20'd128);
    handshake();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'h80;
      mem_b[i] = 8'h80;
    end
    run_op(5, 16);
    check_op("signed_full", 5, 16, 20'd262144);
    handshake();
  endtask
  task automatic test_wrap();
    fill_random();
    run_op(14, 4);
    check_op("wrap", 14, 4, model(14, 4));
    handshake();
  endtask
  task automatic test_zero_len();
    fill_random();
    run_op(3, 0);
    check_op("zero_len", 3, 0, 20'd0);
    handshake();
  endtask
  task automatic test_backpressure();
    logic [19:0] exp;
    fill_random();
    exp = model(7, 3);
    run_op(7, 3);
    check_op("bp_run", 7, 3, exp);
    start = 1;
    len = 5'd2;
    base_addr = 4'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (result_valid !== 1'b1 || result !== exp || busy !== 1'b1 || rd_en !== 1'b0) begin
        errs++;
        $display("FAIL bp_hold[%0d]: got valid=%b result=%0d busy=%b rd_en=%b expected 1 %0d 1 0",
                 i, result_valid, result, busy, rd_en, exp);
      end
    end
    handshake();
    start = 0;
    vectors++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== exp) begin
      errs++;
      $display("FAIL bp_release: got busy=%b valid=%b result=%0d expected 0 0 %0d",
               busy, result_valid, result, exp);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      errs++;
      $display("FAIL bp_start_ignored: got busy=%b rd_en=%b expected 0 0", busy, rd_en);
    end
  endtask
  task automatic test_reset_mid();
    fill_random();
    base_addr = 4'd0;
    len = 5'd16;
    start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    vectors++;
    if ({busy, rd_en, result_valid} !== 3'b000 || result !== 20'd0) begin
      errs++;
      $display("FAIL reset_mid: got busy=%b rd_en=%b valid=%b result=%0d expected 0 0 0 0",
               busy, rd_en, result_valid, result);
    end
    tick();
    run_op(9, 4);
    check_op("after_reset", 9, 4, model(9, 4));
    handshake();
  endtask
  task automatic test_back_to_back();
    for (int n = 0; n < 10; n++) begin
      int b, l;
      fill_random();
      b = int'($urandom_range(0, 15));
      l = int'($urandom_range(0, 16));
      run_op(b, l);
      check_op($sformatf("b2b%0d", n), b, l, model(b, l));
      handshake();
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_wrap();
    test_zero_len();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
